alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage of the 20-bit CPU. Accepts one decoded instruction per handshake and computes the
//  ALU result and flags. Registers the result toward register-file writeback.
//  Owns the 4-bit status register SR = {T,C,S,Z} and resolves the program-flow ops (trap, jumps, LSR, XSR).
// PARAMETERS
//  W        20   full word width
//  HW       10   half-word width (in_mode=0)
//  RA_W     4    register address width
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    decoded op valid
//  in_ready   out  1    stage can accept (in_valid & in_ready = accept)
//  in_op      in   5    opcode (alu_pkg::op_e)
//  in_mode    in   1    1 = full word, 0 = half word
//  in_rd      in   RA_W destination reg; in_rs  in RA_W source reg (swap second write)
//  in_a/in_b  in   W    operands; in_imm in W: jump target / SR value in [3:0]
//  wb_valid   out  1    writeback valid; wb_ready in 1 consumer accepts
//  wb_rd      out  RA_W writeback register; wb_data out W writeback value
//  pc_load    out  1    one-cycle pulse: load pc_target; pc_target out W
//  sr         out  4    status register {T,C,S,Z}
//  trap       out  1    high while halted in TRAP; trap_ack in 1 releases
// BEHAVIOUR
//  Reset: state=IDLE, sr=0, wb_valid=0, wb_rd=0, wb_data=0, pc_load=0, pc_target=0, trap=0; in_ready=1.
//  FSM: IDLE, WB, WB2, TRAP. in_ready=1 only in IDLE, so at most one op is in flight.
//  IDLE accept: compute combinationally and register the results at that edge.
//   Result/flag ops go to WB with wb_valid=1 on the next cycle (latency 1). sr updates at the same edge.
//   SWP: WB (wb_rd=in_rd, data=b), then WB2 (wb_rd=in_rs, data=a).
//   NOP, jumps, LSR, XSR, compares: no writeback; stay in IDLE.
//   TRAP or illegal op (>0x1B): go to TRAP, set sr.T=1.
//  WB/WB2: hold wb_rd/wb_data stable until wb_valid&wb_ready.
//   WB -> IDLE, or WB -> WB2 for SWP. WB2 -> IDLE.
//  TRAP: trap=1, in_ready=0; trap_ack -> IDLE, clear T. trap_ack outside TRAP is ignored.
//  Opcodes: 00 TRAP 01 NOP 02 JMP 03 JZ 04 JS 05 JZS 06 LSR 07 XSR
//   08 NOT 09 AND 0A OR 0B XOR 0C SHR 0D SHL 0E ROR 0F ROL 10 SWP
//   11 INC 12 DEC 13 ADD 14 ADC 15 SUB 16 SBC 17 EQ 18 GT 19 LT 1A GE 1B LE.
//  Width: half mode masks operands to [9:0] and forces result[19:10]=0. Carry is taken out of bit HW-1.
//   Msb is bit W-1 (full) or HW-1 (half).
//  Flags (from the result unless noted):
//   Z = result==0. S = msb.
//   C = carry for ADD/ADC/INC and the shifted-out bit for shifts. For SUB/SBC/DEC, C = borrow.
//   Logic ops and rotates leave C unchanged.
//  Shifts (n = msb index): SHR out[i]=a[i-1], out[0]=0, C=a[n]. SHL out[i]=a[i+1], out[n]=0, C=a[0].
//   ROR/ROL are the same rotations without loss; they do not change C.
//  ADC/SBC add or subtract sr.C. All arithmetic is unsigned mod 2^width.
//  Compares are unsigned, with no writeback. Z=(a==b); S=1 if the relation holds (EQ: S=Z). C unchanged.
//  Jumps use sr as it stands at the accept edge.
//   JMP always; JZ if Z; JS if S; JZS if Z|S.
//   When taken: pc_load=1 for exactly one cycle, pc_target=in_imm. Not taken: no pulse.
//  LSR: sr[2:0]<=in_imm[2:0]. XSR: sr[2:0]<=sr[2:0]^in_imm[2:0]. T is never software-writable.
//  Reset mid-operation: all state is discarded at once; a pending writeback is dropped.
// STRUCTURE
//  alu_pkg: op_e enum (codes above), SR bit index constants (Z=0,S=1,C=2,T=3), W/HW localparams.
//  Sub-module alu_datapath: combinational (op, mode, a, b, cin) -> (result, z, s, c, c_en, wb_en, illegal).
//  The FSM, sr, and output registers stay in alu_exec_stage.
// TESTING
//  Full-mode ADD a=0xFFFFF b=0x00001, wb_ready=1 -> next cycle wb_data=0, sr Z=1 C=1 S=0. ADC of 0+0 -> wb_data=1.
//  Half-mode SUB a=0x00003 b=0x00005 -> wb_data=0x003FE (bits 19:10 zero); sr S=1, C=1 (borrow).
//  SWP rd=2 rs=5 a=0x12345 b=0x0ABCD, wb_ready low 3 cycles:
//   wb (2,0x0ABCD) held stable, then (5,0x12345); in_ready=0 throughout.
//  EQ a=b, then JZ imm=0x00400 -> pc_load one cycle with pc_target=0x00400, no wb_valid.
//   The same JZ after an LSR with imm=0 -> no pulse.
//  op=0x1F -> trap=1, sr.T=1, in_ready=0; trap_ack -> IDLE, T=0.
//   Asserting rst_n=0 during WB -> all outputs reach reset values with no clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 20-bit CPU execute stage: opcodes, SR bit indices,
// FSM states and the half-word masking helper.
package alu_pkg;
    localparam int W    = 20;
    localparam int HW   = 10;
    localparam int RA_W = 4;

    localparam int SR_Z = 0;
    localparam int SR_S = 1;
    localparam int SR_C = 2;
    localparam int SR_T = 3;

    typedef enum logic [4:0] {
        OP_TRAP = 5'h00, OP_NOP = 5'h01, OP_JMP = 5'h02, OP_JZ  = 5'h03,
        OP_JS   = 5'h04, OP_JZS = 5'h05, OP_LSR = 5'h06, OP_XSR = 5'h07,
        OP_NOT  = 5'h08, OP_AND = 5'h09, OP_OR  = 5'h0A, OP_XOR = 5'h0B,
        OP_SHR  = 5'h0C, OP_SHL = 5'h0D, OP_ROR = 5'h0E, OP_ROL = 5'h0F,
        OP_SWP  = 5'h10, OP_INC = 5'h11, OP_DEC = 5'h12, OP_ADD = 5'h13,
        OP_ADC  = 5'h14, OP_SUB = 5'h15, OP_SBC = 5'h16, OP_EQ  = 5'h17,
        OP_GT   = 5'h18, OP_LT  = 5'h19, OP_GE  = 5'h1A, OP_LE  = 5'h1B
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_WB2, ST_TRAP} state_e;

    function automatic logic [W-1:0] mask_word(input logic [W-1:0] v, input logic mode);
        return mode ? v : {{(W-HW){1'b0}}, v[HW-1:0]};
    endfunction
endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: result and flag candidates for one decoded op in full or half width.
module alu_datapath
    import alu_pkg::*;
(
    input  logic [4:0]   op_i,
    input  logic         mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] result_o,
    output logic         z_o,
    output logic         s_o,
    output logic         c_o,
    output logic         c_en_o,
    output logic         wb_en_o,
    output logic         illegal_o
);
    logic [W-1:0] a_m, b_m, raw, msb_mask;
    logic [W:0]   ext;
    logic         msb_a, carry_pos, cmp, rel;

    always_comb begin
        a_m       = mask_word(a_i, mode_i);
        b_m       = mask_word(b_i, mode_i);
        msb_mask  = mode_i ? {1'b1, {(W-1){1'b0}}} : {{(W-HW){1'b0}}, 1'b1, {(HW-1){1'b0}}};
        msb_a     = |(a_m & msb_mask);
        raw       = '0;
        ext       = '0;
        c_o       = 1'b0;
        c_en_o    = 1'b0;
        wb_en_o   = 1'b0;
        illegal_o = 1'b0;
        cmp       = 1'b0;
        rel       = 1'b0;
        case (op_e'(op_i))
            OP_TRAP, OP_NOP, OP_JMP, OP_JZ, OP_JS, OP_JZS, OP_LSR, OP_XSR: ;
            OP_NOT: begin raw = ~a_m;      wb_en_o = 1'b1; end
            OP_AND: begin raw = a_m & b_m; wb_en_o = 1'b1; end
            OP_OR:  begin raw = a_m | b_m; wb_en_o = 1'b1; end
            OP_XOR: begin raw = a_m ^ b_m; wb_en_o = 1'b1; end
            OP_SHR: begin raw = {a_m[W-2:0], 1'b0}; c_o = msb_a;  c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_SHL: begin raw = {1'b0, a_m[W-1:1]}; c_o = a_m[0]; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_ROR: begin raw = {a_m[W-2:0], 1'b0} | {{(W-1){1'b0}}, msb_a}; wb_en_o = 1'b1; end
            OP_ROL: begin raw = {1'b0, a_m[W-1:1]} | (a_m[0] ? msb_mask : '0); wb_en_o = 1'b1; end
            OP_SWP: begin raw = b_m; wb_en_o = 1'b1; end
            OP_INC: begin ext = {1'b0, a_m} + {{W{1'b0}}, 1'b1}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_DEC: begin ext = {1'b0, a_m} - {{W{1'b0}}, 1'b1}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_ADD: begin ext = {1'b0, a_m} + {1'b0, b_m}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_ADC: begin ext = {1'b0, a_m} + {1'b0, b_m} + {{W{1'b0}}, cin_i}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_SUB: begin ext = {1'b0, a_m} - {1'b0, b_m}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_SBC: begin ext = {1'b0, a_m} - {1'b0, b_m} - {{W{1'b0}}, cin_i}; c_en_o = 1'b1; wb_en_o = 1'b1; end
            OP_EQ:  begin cmp = 1'b1; rel = (a_m == b_m); end
            OP_GT:  begin cmp = 1'b1; rel = (a_m >  b_m); end
            OP_LT:  begin cmp = 1'b1; rel = (a_m <  b_m); end
            OP_GE:  begin cmp = 1'b1; rel = (a_m >= b_m); end
            OP_LE:  begin cmp = 1'b1; rel = (a_m <= b_m); end
            default: illegal_o = 1'b1;
        endcase
        // Arithmetic ops leave their sum in ext; the wrap bit above the active msb is carry/borrow.
        carry_pos = mode_i ? ext[W] : ext[HW];
        if (op_i >= 5'(OP_INC) && op_i <= 5'(OP_SBC)) begin
            raw = ext[W-1:0];
            c_o = carry_pos;
        end
        result_o = mask_word(raw, mode_i);
        z_o      = cmp ? (a_m == b_m) : (result_o == '0);
        s_o      = cmp ? rel : |(result_o & msb_mask);
    end
endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one op in flight, registered writeback (two writes for SWP),
// status register ownership, program-flow resolution and trap halt.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic            in_mode,
    input  logic [RA_W-1:0] in_rd,
    input  logic [RA_W-1:0] in_rs,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [W-1:0]    in_imm,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RA_W-1:0] wb_rd,
    output logic [W-1:0]    wb_data,
    output logic            pc_load,
    output logic [W-1:0]    pc_target,
    output logic [3:0]      sr,
    output logic            trap,
    input  logic            trap_ack
);
    state_e          state_q, state_d;
    logic [3:0]      sr_q, sr_d;
    logic            wb_valid_q, wb_valid_d, pc_load_q, pc_load_d, swp_pend_q, swp_pend_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d, swp_rd_q, swp_rd_d;
    logic [W-1:0]    wb_data_q, wb_data_d, pc_target_q, pc_target_d, swp_data_q, swp_data_d;
    logic [W-1:0]    result;
    logic            z, s, c, c_en, wb_en, illegal, take;

    alu_datapath u_datapath (
        .op_i(in_op), .mode_i(in_mode), .a_i(in_a), .b_i(in_b), .cin_i(sr_q[SR_C]),
        .result_o(result), .z_o(z), .s_o(s), .c_o(c), .c_en_o(c_en),
        .wb_en_o(wb_en), .illegal_o(illegal)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        pc_load_d   = 1'b0;
        pc_target_d = pc_target_q;
        swp_pend_d  = swp_pend_q;
        swp_rd_d    = swp_rd_q;
        swp_data_d  = swp_data_q;
        take        = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                if (in_op == 5'(OP_TRAP) || illegal) begin
                    state_d      = ST_TRAP;
                    sr_d[SR_T]   = 1'b1;
                end else begin
                    if (in_op >= 5'(OP_NOT)) begin
                        sr_d[SR_Z] = z;
                        sr_d[SR_S] = s;
                        if (c_en) sr_d[SR_C] = c;
                    end
                    if (wb_en) begin
                        state_d    = ST_WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_data_d  = result;
                        swp_pend_d = (in_op == 5'(OP_SWP));
                        swp_rd_d   = in_rs;
                        swp_data_d = mask_word(in_a, in_mode);
                    end
                    // Jump conditions look at sr as it was before this op.
                    case (op_e'(in_op))
                        OP_JMP:  take = 1'b1;
                        OP_JZ:   take = sr_q[SR_Z];
                        OP_JS:   take = sr_q[SR_S];
                        OP_JZS:  take = sr_q[SR_Z] | sr_q[SR_S];
                        OP_LSR:  sr_d[2:0] = in_imm[2:0];
                        OP_XSR:  sr_d[2:0] = sr_q[2:0] ^ in_imm[2:0];
                        default: ;
                    endcase
                    if (take) begin
                        pc_load_d   = 1'b1;
                        pc_target_d = in_imm;
                    end
                end
            end
            ST_WB: if (wb_ready) begin
                if (swp_pend_q) begin
                    state_d    = ST_WB2;
                    wb_rd_d    = swp_rd_q;
                    wb_data_d  = swp_data_q;
                    swp_pend_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            ST_WB2: if (wb_ready) begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b0;
            end
            ST_TRAP: if (trap_ack) begin
                state_d    = ST_IDLE;
                sr_d[SR_T] = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            swp_pend_q  <= 1'b0;
            swp_rd_q    <= '0;
            swp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            swp_pend_q  <= swp_pend_d;
            swp_rd_q    <= swp_rd_d;
            swp_data_q  <= swp_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign trap      = (state_q == ST_TRAP);
    assign sr        = sr_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
endmodule
